// File: rtl/ram_memory_mp.sv
// ram_memory_mp: byte-strobed single-write, multi-read word RAM at ADDR_BASE with zero-fill sweep after reset.
// Reads are registered with write-first forwarding; out-of-range accesses raise registered error flags.
module ram_memory_mp #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_BASE  = 10,
  parameter int MEM_SIZE   = 32,
  parameter int READ_PORTS = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             write_en,
  input  logic [BUS_WIDTH/8-1:0]           write_strb,
  input  logic [BUS_WIDTH-1:0]             addr_write,
  input  logic [BUS_WIDTH-1:0]             data_write,
  input  logic [READ_PORTS*BUS_WIDTH-1:0]  addr_read,
  output logic [READ_PORTS*BUS_WIDTH-1:0]  data_read,
  output logic [READ_PORTS-1:0]            read_err,
  output logic                             write_err,
  output logic                             ready
);
  localparam int NB = BUS_WIDTH / 8;
  localparam int AW = $clog2(MEM_SIZE);
  localparam logic [BUS_WIDTH-1:0] LO = BUS_WIDTH'(ADDR_BASE);
  localparam logic [BUS_WIDTH-1:0] HI = BUS_WIDTH'(ADDR_BASE + MEM_SIZE - 1);
  localparam logic [AW-1:0] LAST = AW'(MEM_SIZE - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_cnt, w_widx;
  logic [BUS_WIDTH-1:0] r_mem [MEM_SIZE];
  logic [BUS_WIDTH-1:0] w_merged;
  logic w_win, w_wvalid, r_werr;
  always_ff @(posedge clk)
    if (reset) r_state <= INIT;
    else r_state <= w_next;
  always_comb w_next = (r_state == INIT && r_cnt == LAST) ? RUN : r_state;
  always_comb ready = r_state == RUN;
  always_ff @(posedge clk)
    r_cnt <= (reset || r_state != INIT || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  assign w_win    = addr_write >= LO && addr_write <= HI;
  assign w_widx   = AW'(addr_write - LO);
  assign w_wvalid = write_en && w_win && r_state == RUN;
  always_comb begin
    w_merged = r_mem[w_widx];
    for (int k = 0; k < NB; k++)
      w_merged[8*k +: 8] = write_strb[k] ? data_write[8*k +: 8] : r_mem[w_widx][8*k +: 8];
  end
  // Contents are deliberately left alone on the reset edge; the sweep clears them.
  always_ff @(posedge clk)
    if (!reset) begin
      if (r_state == INIT) r_mem[r_cnt] <= '0;
      else if (w_wvalid) r_mem[w_widx] <= w_merged;
    end
  always_ff @(posedge clk) r_werr <= !reset && r_state == RUN && write_en && !w_win;
  assign write_err = r_werr;
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [BUS_WIDTH-1:0] w_ra, r_rdata;
    logic [AW-1:0] w_ridx;
    logic w_rin, r_rerr;
    assign w_ra   = addr_read[p*BUS_WIDTH +: BUS_WIDTH];
    assign w_rin  = w_ra >= LO && w_ra <= HI;
    assign w_ridx = AW'(w_ra - LO);
    always_ff @(posedge clk)
      if (reset || r_state == INIT) begin
        r_rdata <= '0;
        r_rerr  <= 1'b0;
      end else begin
        r_rdata <= !w_rin ? '0 : (w_wvalid && w_widx == w_ridx) ? w_merged : r_mem[w_ridx];
        r_rerr  <= !w_rin;
      end
    assign data_read[p*BUS_WIDTH +: BUS_WIDTH] = r_rdata;
    assign read_err[p] = r_rerr;
  end
endmodule

// File: tb/tb_ram_memory_mp.sv
// tb_ram_memory_mp: randomized + directed scoreboard bench for ram_memory_mp against an address-level model.
module tb_ram_memory_mp;
  localparam int AB = 10;
  localparam int MS = 32;
  logic        clk, reset, write_en, write_err, ready;
  logic [3:0]  write_strb;
  logic [31:0] addr_write, data_write;
  logic [63:0] addr_read, data_read;
  logic [1:0]  read_err;
  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  re;
    logic        we;
    logic        rdy;
  } exp_t;
  exp_t q[$];
  logic [31:0] mm [MS];
  int left = MS;
  int total = 0;
  int bad = 0;
  ram_memory_mp #(.BUS_WIDTH(32), .ADDR_BASE(AB), .MEM_SIZE(MS), .READ_PORTS(2)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .write_strb(write_strb),
    .addr_write(addr_write), .data_write(data_write), .addr_read(addr_read),
    .data_read(data_read), .read_err(read_err), .write_err(write_err), .ready(ready)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic bit inr(input logic [31:0] a);
    return a >= 32'(AB) && a <= 32'(AB + MS - 1);
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, a, x, $time);
    end
  endtask
  // Inputs for the next edge are applied on the falling edge and the expected outcome queued.
  task automatic step(input logic r, input logic we, input logic [3:0] sb, input logic [31:0] wa,
                      input logic [31:0] wd, input logic [31:0] ra0, input logic [31:0] ra1);
    exp_t e;
    logic [31:0] ra;
    @(negedge clk);
    reset = r; write_en = we; write_strb = sb; addr_write = wa; data_write = wd;
    addr_read = {ra1, ra0};
    e = '0;
    if (r) left = MS;
    else if (left > 0) begin
      mm[MS - left] = 32'h0;
      left--;
      e.rdy = (left == 0);
    end else begin
      e.rdy = 1'b1;
      if (we && inr(wa)) begin
        for (int k = 0; k < 4; k++)
          if (sb[k]) mm[int'(wa - AB)][8*k +: 8] = wd[8*k +: 8];
      end else if (we) e.we = 1'b1;
      for (int p = 0; p < 2; p++) begin
        ra = p == 0 ? ra0 : ra1;
        if (inr(ra)) e.d[32*p +: 32] = mm[int'(ra - AB)];
        else e.re[p] = 1'b1;
      end
    end
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("data_read", data_read, e.d);
      chk("read_err", 64'(read_err), 64'(e.re));
      chk("write_err", 64'(write_err), 64'(e.we));
      chk("ready", 64'(ready), 64'(e.rdy));
    end
  end
  function automatic logic [31:0] raddr();
    return $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(8, 43));
  endfunction
  initial begin
    reset = 1; write_en = 0; write_strb = 0; addr_write = 0; data_write = 0; addr_read = 0;
    for (int i = 0; i < MS; i++) mm[i] = 32'h0;
    step(1, 0, 0, 0, 0, 10, 10);
    step(1, 0, 0, 0, 0, 10, 10);
    for (int i = 0; i < MS; i++) step(0, 1, 4'hF, 32'($urandom_range(10, 41)), $urandom, 32'($urandom_range(10, 41)), 9);
    for (int a = 10; a < 42; a += 2) step(0, 0, 0, 0, 0, 32'(a), 32'(a + 1));
    step(0, 1, 4'hF, 11, 32'hDEADBEEF, 10, 10);
    step(0, 0, 0, 0, 0, 11, 10);
    step(0, 1, 4'h3, 11, 32'h00001234, 11, 11);
    step(0, 0, 0, 0, 0, 11, 11);
    step(0, 1, 4'hF, 41, 32'h00000001, 41, 41);
    step(0, 0, 0, 0, 0, 9, 42);
    step(0, 1, 4'hF, 42, 32'hCAFEF00D, 41, 41);
    step(0, 0, 0, 0, 0, 41, 42);
    step(0, 1, 4'h0, 12, 32'hFFFFFFFF, 12, 12);
    step(0, 1, 4'hF, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 12);
    step(1, 0, 0, 0, 0, 11, 11);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 11, 41);
    step(1, 0, 0, 0, 0, 11, 11);
    for (int i = 0; i < MS + 1; i++) step(0, 0, 0, 0, 0, 11, 41);
    step(0, 1, 4'hF, 11, 32'h55555555, 11, 12);
    step(0, 0, 0, 0, 0, 11, 12);
    step(1, 1, 4'hF, 12, 32'h77777777, 12, 11);
    for (int i = 0; i < MS + 2; i++) step(0, 0, 0, 0, 0, 11, 12);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 149) == 0, 1'($urandom), 4'($urandom), raddr(), $urandom, raddr(), raddr());
    @(negedge clk);
    @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
